// File: rtl/day_month_counter_if.sv
// Bundle of control, year and calendar signals between the clock/set logic and the
// day/month stage. The master side drives the controls and the year; the slave side
// (the counter) drives day, month, carry and the leap flag.
interface day_month_counter_if;
  logic        carry_in_day;
  logic        ctrl_set;
  logic        sel_month;
  logic        inc;
  logic        dec;
  logic [11:0] year_count;
  logic [4:0]  day_count;
  logic [3:0]  month_count;
  logic        carry_out_month;
  logic        leap_year;

  modport master (
    output carry_in_day, ctrl_set, sel_month, inc, dec, year_count,
    input  day_count, month_count, carry_out_month, leap_year
  );

  modport slave (
    input  carry_in_day, ctrl_set, sel_month, inc, dec, year_count,
    output day_count, month_count, carry_out_month, leap_year
  );
endinterface

// File: rtl/day_month_counter.sv
// Calendar day/month stage: advances on the daily carry, applies leap rules, manual set.
// Latency: every update is registered, visible one cycle after the causing input.
// No backpressure: carry_in_day is consumed on the cycle it arrives (dropped in set mode).
module day_month_counter #(
  parameter int BASE_YEAR = 2025,
  parameter int MAX_YEAR  = 3025
) (
  input  logic               clk,
  input  logic               rst,
  day_month_counter_if.slave bus
);

  // The year range must fit the 12-bit year input and be ordered.
  if (MAX_YEAR > 4095 || BASE_YEAR > MAX_YEAR) begin : g_bad_year_range
    $error("day_month_counter: year range does not fit 12-bit year_count");
  end

  // Days in a month; illegal month codes report 31 so they never trigger a clamp.
  function automatic logic [4:0] days_in(input logic [3:0] m, input logic leap);
    logic [4:0] d;
    d = 5'd31;
    case (m)
      4'd2:                      d = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   d = 5'd30;
      default:                   d = 5'd31;
    endcase
    return d;
  endfunction

  logic [4:0] day_q;
  logic [3:0] month_q;
  logic       carry_q;

  logic [4:0] day_nxt;
  logic [3:0] month_nxt;
  logic       carry_nxt;

  logic       leap;
  logic [4:0] dim_cur;
  logic [4:0] dim_new;
  logic [3:0] month_step;
  logic       month_bad;
  logic       day_bad;

  // Gregorian leap rule, straight from the year value; no state involved.
  always_comb begin
    leap = 1'b0;
    if ((bus.year_count % 12'd400) == 12'd0) begin
      leap = 1'b1;
    end else if ((bus.year_count[1:0] == 2'b00) &&
                 ((bus.year_count % 12'd100) != 12'd0)) begin
      leap = 1'b1;
    end
  end

  // Next day/month/carry: sanitise > manual set > daily tick > clamp.
  always_comb begin
    day_nxt    = day_q;
    month_nxt  = month_q;
    carry_nxt  = 1'b0;
    month_step = month_q;
    dim_cur    = days_in(month_q, leap);
    dim_new    = dim_cur;
    month_bad  = (month_q == 4'd0) || (month_q > 4'd12);
    day_bad    = (day_q == 5'd0);

    if (month_bad || day_bad) begin
      // Illegal codes cannot come from normal operation; recover to 1 quickly.
      if (month_bad) month_nxt = 4'd1;
      if (day_bad)   day_nxt   = 5'd1;
    end else if (bus.ctrl_set) begin
      // Set mode swallows the daily tick; inc beats dec when both are high.
      if (bus.inc || bus.dec) begin
        if (!bus.sel_month) begin
          if (bus.inc) begin
            day_nxt = (day_q >= dim_cur) ? 5'd1 : day_q + 5'd1;
          end else begin
            day_nxt = (day_q == 5'd1) ? dim_cur : day_q - 5'd1;
          end
        end else begin
          if (bus.inc) begin
            month_step = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
          end else begin
            month_step = (month_q == 4'd1) ? 4'd12 : month_q - 4'd1;
          end
          month_nxt = month_step;
          // Keep the day valid for the month being moved into.
          dim_new   = days_in(month_step, leap);
          day_nxt   = (day_q > dim_new) ? dim_new : day_q;
        end
      end
    end else if (bus.carry_in_day) begin
      if (day_q < dim_cur) begin
        day_nxt = day_q + 5'd1;
      end else if (month_q < 4'd12) begin
        day_nxt   = 5'd1;
        month_nxt = month_q + 4'd1;
      end else begin
        day_nxt   = 5'd1;
        month_nxt = 4'd1;
        carry_nxt = 1'b1;
      end
    end else if (day_q > dim_cur) begin
      // A year change can leave 29 Feb in a non-leap year; pull it back.
      day_nxt = dim_cur;
    end
  end

  // Calendar state register; reset lands on 1 January with no carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      day_q   <= 5'd1;
      month_q <= 4'd1;
      carry_q <= 1'b0;
    end else begin
      day_q   <= day_nxt;
      month_q <= month_nxt;
      carry_q <= carry_nxt;
    end
  end

  assign bus.day_count       = day_q;
  assign bus.month_count     = month_q;
  assign bus.carry_out_month = carry_q;
  assign bus.leap_year       = leap;

endmodule
